// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - register map, control layout and bus FSM states for wb_timer
package timer_pkg;

    typedef enum logic [2:0] {
        REG_CTRL     = 3'd0,
        REG_PRESCALE = 3'd1,
        REG_RELOAD   = 3'd2,
        REG_COUNT    = 3'd3,
        REG_STATUS   = 3'd4
    } reg_addr_t;

    localparam int CTRL_EN        = 0;
    localparam int CTRL_AUTO      = 1;
    localparam int CTRL_IRQ_EN    = 2;
    localparam int STATUS_EXPIRED = 0;

    typedef struct packed {
        logic irq_en;
        logic auto_rl;
        logic en;
    } ctrl_t;

    typedef enum logic [1:0] {
        BUS_IDLE,
        BUS_WAIT,
        BUS_ACK
    } bus_state_t;

    function automatic ctrl_t ctrl_from_word(input logic [15:0] w);
        ctrl_t c;
        c.irq_en  = w[CTRL_IRQ_EN];
        c.auto_rl = w[CTRL_AUTO];
        c.en      = w[CTRL_EN];
        return c;
    endfunction

endpackage

// File: rtl/if_wb.sv
// rtl/if_wb.sv - 16-bit Wishbone bus shared by the J1 CPU and its peripherals
interface if_wb;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [15:0] adr;
    logic [15:0] dat_m;
    logic [15:0] dat_s;
    logic        ack;

    modport master (output cyc, stb, we, adr, dat_m, input ack, dat_s);
    modport slave  (input cyc, stb, we, adr, dat_m, output ack, dat_s);
endinterface

// File: rtl/timer_core.sv
// rtl/timer_core.sv - prescaler, down counter, sticky expiry flag and registered irq
module timer_core
    import timer_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  ctrl_t       ctrl,
    input  logic        ctrl_we,
    input  logic        ctrl_wdata_en,
    input  logic [15:0] prescale,
    input  logic [15:0] reload,
    input  logic        count_we,
    input  logic        status_we,
    input  logic [15:0] wdata,
    output logic [15:0] count,
    output logic        expired,
    output logic        en_clear,
    output logic        irq
);

    logic [15:0] psc_cnt;
    logic        tick;
    logic        expire;
    logic        en_rise;

    always_comb begin
        tick     = ctrl.en && (psc_cnt == 16'd0);
        expire   = tick && (count == 16'd0);
        en_clear = expire && !ctrl.auto_rl;
        en_rise  = ctrl_we && ctrl_wdata_en && !ctrl.en;
    end

    // Enabling restarts the prescale period so the first tick is PRESCALE+1 cycles out
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            psc_cnt <= 16'd0;
        end else if (en_rise) begin
            psc_cnt <= prescale;
        end else if (ctrl.en) begin
            if (psc_cnt == 16'd0) begin
                psc_cnt <= prescale;
            end else begin
                psc_cnt <= psc_cnt - 16'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= 16'd0;
        end else if (count_we) begin
            count <= wdata;
        end else if (tick) begin
            if (!expire) begin
                count <= count - 16'd1;
            end else if (ctrl.auto_rl) begin
                count <= reload;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            expired <= 1'b0;
        end else if (expire) begin
            expired <= 1'b1;
        end else if (status_we && wdata[STATUS_EXPIRED]) begin
            expired <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq <= 1'b0;
        end else begin
            irq <= expired && ctrl.irq_en;
        end
    end

endmodule

// File: rtl/wb_timer.sv
// rtl/wb_timer.sv - Wishbone timer peripheral: bus FSM, register bank and read mux
module wb_timer
    import timer_pkg::*;
#(
    parameter int          WAIT_STATES   = 0,
    parameter logic [15:0] PRESCALE_INIT = 16'h0000
) (
    input  logic  clk,
    input  logic  reset,
    if_wb.slave   wb,
    output logic  irq
);

    localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    bus_state_t  state;
    bus_state_t  state_next;
    logic [3:0]  wait_cnt;
    logic [3:0]  wait_cnt_next;
    logic        capture;
    reg_addr_t   adr_q;
    logic        we_q;
    logic [15:0] wdata_q;

    ctrl_t       ctrl;
    logic [15:0] prescale;
    logic [15:0] reload;
    logic [15:0] count;
    logic        expired;
    logic        en_clear;

    logic        ack_cycle;
    logic        wr;
    logic [15:0] rdata;
    logic        unused_adr;

    assign unused_adr = ^wb.adr[15:3];

    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        capture       = 1'b0;
        case (state)
            BUS_IDLE: begin
                if (wb.cyc && wb.stb) begin
                    capture = 1'b1;
                    if (WAIT_STATES > 0) begin
                        state_next    = BUS_WAIT;
                        wait_cnt_next = WAIT_LOAD;
                    end else begin
                        state_next = BUS_ACK;
                    end
                end
            end
            BUS_WAIT: begin
                if (wait_cnt == 4'd0) begin
                    state_next = BUS_ACK;
                end else begin
                    wait_cnt_next = wait_cnt - 4'd1;
                end
            end
            BUS_ACK:  state_next = BUS_IDLE;
            default:  state_next = BUS_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= BUS_IDLE;
            wait_cnt <= 4'd0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
        end
    end

    // The request is frozen at capture so a misbehaving master cannot alter it mid-access
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            adr_q   <= REG_CTRL;
            we_q    <= 1'b0;
            wdata_q <= 16'd0;
        end else if (capture) begin
            adr_q   <= reg_addr_t'(wb.adr[2:0]);
            we_q    <= wb.we;
            wdata_q <= wb.dat_m;
        end
    end

    assign ack_cycle = (state == BUS_ACK);
    assign wr        = ack_cycle && we_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl <= '0;
        end else if (wr && adr_q == REG_CTRL) begin
            ctrl <= ctrl_from_word(wdata_q);
        end else if (en_clear) begin
            ctrl.en <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prescale <= PRESCALE_INIT;
            reload   <= 16'd0;
        end else begin
            if (wr && adr_q == REG_PRESCALE) prescale <= wdata_q;
            if (wr && adr_q == REG_RELOAD)   reload   <= wdata_q;
        end
    end

    timer_core u_core (
        .clk           (clk),
        .reset         (reset),
        .ctrl          (ctrl),
        .ctrl_we       (wr && adr_q == REG_CTRL),
        .ctrl_wdata_en (wdata_q[CTRL_EN]),
        .prescale      (prescale),
        .reload        (reload),
        .count_we      (wr && adr_q == REG_COUNT),
        .status_we     (wr && adr_q == REG_STATUS),
        .wdata         (wdata_q),
        .count         (count),
        .expired       (expired),
        .en_clear      (en_clear),
        .irq           (irq)
    );

    always_comb begin
        rdata = 16'd0;
        case (adr_q)
            REG_CTRL:     rdata = {13'd0, ctrl};
            REG_PRESCALE: rdata = prescale;
            REG_RELOAD:   rdata = reload;
            REG_COUNT:    rdata = count;
            REG_STATUS:   rdata = {15'd0, expired};
            default:      rdata = 16'd0;
        endcase
    end

    assign wb.ack   = ack_cycle;
    assign wb.dat_s = ack_cycle ? rdata : 16'd0;

endmodule
